minisys_if: RTL and testbench

- Instruction-fetch stage of the Minisys pipelined CPU; directly upstream of the decode stage.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Handles stall, flush and branch/jump redirect from decode.
- Drives the IF/ID pipeline register (instrD, pcplus4D, validD) consumed by decode.

---
 rtl/minisys_if.sv | 223 ++++++++++++++++++++++
 tb/tb_minisys_if.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minisys_if.sv
// -----------------------------------------------------------------------------
// minisys_if : instruction-fetch stage of the Minisys pipelined CPU.
//
// Owns the PC and fetches one word at a time from instruction memory over a
// req/ack handshake. It handles stall, flush and branch/jump redirects from
// decode, and drives the IF/ID pipeline register consumed by decode.
//
// Ports
//   clk         single clock, all state on the rising edge
//   clrn        synchronous active-high reset
//   stallF      hold PC and IF/ID contents
//   flushD      load a bubble into IF/ID this edge
//   pcsrcD      branch taken (target pcbranchD)
//   jumpD       jump taken (target pcjumpD, wins over a branch)
//   imem_req    fetch request, held until imem_ack
//   imem_addr   fetch word address (= PC)
//   imem_rdata  fetched instruction, valid with imem_ack
//   imem_ack    one-cycle fetch-complete pulse
//   instrD      IF/ID instruction
//   pcplus4D    IF/ID PC+4
//   validD      IF/ID holds a real instruction
//   excD        IF/ID misaligned-target exception (MINISYS_IF_ALIGN_CHK_EN only)
//
// Build option
//   MINISYS_IF_ALIGN_CHK_EN : redirect targets with addr[1:0] != 0 are not
//   fetched; a NOP with excD=1 is delivered instead and fetching resumes at
//   the next aligned word. Without it, targets are fetched as given.
// -----------------------------------------------------------------------------
module minisys_if #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stallF,
    input  logic        flushD,
    input  logic        pcsrcD,
    input  logic [31:0] pcbranchD,
    input  logic        jumpD,
    input  logic [31:0] pcjumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
`ifdef MINISYS_IF_ALIGN_CHK_EN
    output logic        excD,
`endif
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD
);

`ifdef MINISYS_IF_ALIGN_CHK_EN
    localparam logic ALIGN_CHK = 1'b1;
`else
    localparam logic ALIGN_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] tgt, tgt_nxt;
    logic [31:0] hold_instr, hold_nxt;
    logic        kill, kill_nxt;
    logic        hold_exc, hold_exc_nxt;

    logic        ld;
    logic [31:0] ld_instr;
    logic [31:0] ld_pc4;

    logic        redir;
    logic        accept;
    logic [31:0] target;
    logic [31:0] redir_pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_al_plus4;
    logic [31:0] resume_pc;

    function automatic logic misaligned(input logic [31:0] addr);
        return ALIGN_CHK && (addr[1:0] != 2'b00);
    endfunction

    assign redir       = jumpD | pcsrcD;
    assign target      = jumpD ? pcjumpD : pcbranchD;
    // A flushed instruction still counts as consumed by IF/ID, so the fetch
    // path moves on even if stallF is high.
    assign accept      = ~stallF | flushD;
    // On an ack, a fresh redirect is newer than any pending killed target.
    assign redir_pc    = redir ? target : tgt;
    assign pc_plus4    = pc + 32'd4;
    assign pc_al_plus4 = {pc[31:2], 2'b00} + 32'd4;
    // After a misaligned-target exception, resume at the next aligned word.
    assign resume_pc   = hold_exc ? pc_al_plus4 : pc_plus4;

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (clrn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state and fetch-path logic ----
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        kill_nxt     = kill;
        tgt_nxt      = tgt;
        hold_nxt     = hold_instr;
        hold_exc_nxt = hold_exc;
        ld           = 1'b0;
        ld_instr     = imem_rdata;
        ld_pc4       = pc_plus4;
        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (redir || kill) begin
                        // Word belongs to the wrong path: drop it.
                        pc_nxt   = redir_pc;
                        kill_nxt = 1'b0;
                        if (misaligned(redir_pc)) begin
                            hold_exc_nxt = 1'b1;
                            state_nxt    = S_HOLD;
                        end
                    end else if (accept) begin
                        ld     = 1'b1;
                        pc_nxt = pc_plus4;
                    end else begin
                        hold_nxt     = imem_rdata;
                        hold_exc_nxt = 1'b0;
                        state_nxt    = S_HOLD;
                    end
                end else if (redir) begin
                    // The request cannot be withdrawn; remember where to go.
                    kill_nxt = 1'b1;
                    tgt_nxt  = target;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_nxt       = target;
                    hold_exc_nxt = misaligned(target);
                    state_nxt    = misaligned(target) ? S_HOLD : S_REQ;
                end else if (accept) begin
                    ld           = 1'b1;
                    ld_instr     = hold_exc ? NOP_INSTR : hold_instr;
                    ld_pc4       = resume_pc;
                    pc_nxt       = resume_pc;
                    hold_exc_nxt = 1'b0;
                    state_nxt    = S_REQ;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---- output logic ----
    always_comb begin
        imem_req  = (state == S_REQ);
        imem_addr = pc;
    end

    // ---- fetch-path registers ----
    always_ff @(posedge clk) begin
        if (clrn) begin
            pc       <= RESET_PC;
            kill     <= 1'b0;
            hold_exc <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            kill     <= kill_nxt;
            hold_exc <= hold_exc_nxt;
        end
    end

    // Only read when kill / S_HOLD says they are meaningful, so no reset.
    always_ff @(posedge clk) begin
        tgt        <= tgt_nxt;
        hold_instr <= hold_nxt;
    end

    // ---- IF/ID pipeline register ----
    always_ff @(posedge clk) begin
        if (clrn) begin
            instrD   <= NOP_INSTR;
            pcplus4D <= '0;
            validD   <= 1'b0;
        end else if (flushD) begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
        end else if (ld) begin
            instrD   <= ld_instr;
            pcplus4D <= ld_pc4;
            validD   <= 1'b1;
        end
    end

`ifdef MINISYS_IF_ALIGN_CHK_EN
    logic ld_exc;
    // Only an S_HOLD load can carry the exception marker.
    assign ld_exc = (state == S_HOLD) && hold_exc;

    always_ff @(posedge clk) begin
        if (clrn || flushD) begin
            excD <= 1'b0;
        end else if (ld) begin
            excD <= ld_exc;
        end
    end
`endif

endmodule

// File: tb/tb_minisys_if.sv
module tb_minisys_if;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef MINISYS_IF_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clrn;
    logic        stallF;
    logic        flushD;
    logic        pcsrcD;
    logic [31:0] pcbranchD;
    logic        jumpD;
    logic [31:0] pcjumpD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instrD;
    logic [31:0] pcplus4D;
    logic        validD;
`ifdef MINISYS_IF_ALIGN_CHK_EN
    logic        excD;
`endif

    always #5 clk = ~clk;

    minisys_if dut (
        .clk       (clk),
        .clrn      (clrn),
        .stallF    (stallF),
        .flushD    (flushD),
        .pcsrcD    (pcsrcD),
        .pcbranchD (pcbranchD),
        .jumpD     (jumpD),
        .pcjumpD   (pcjumpD),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ack  (imem_ack),
`ifdef MINISYS_IF_ALIGN_CHK_EN
        .excD      (excD),
`endif
        .instrD    (instrD),
        .pcplus4D  (pcplus4D),
        .validD    (validD)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit          m_started, m_hold, m_kill, m_hold_exc, m_valid;
    logic [31:0] m_pc, m_tgt, m_hold_word, m_instr, m_pc4;
`ifdef MINISYS_IF_ALIGN_CHK_EN
    bit          m_exc;
`endif

    function automatic bit bad(input logic [31:0] a);
        return ALIGN && (a[1:0] != 2'b00);
    endfunction

    task automatic model_step();
        bit          redirect, take, give, g_exc;
        logic [31:0] dest, g_instr, g_pc4;
        give = 1'b0; g_exc = 1'b0; g_instr = NOP; g_pc4 = 32'd0;
        if (clrn) begin
            m_started = 1'b0; m_hold = 1'b0; m_kill = 1'b0; m_hold_exc = 1'b0;
            m_pc = 32'd0; m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
`ifdef MINISYS_IF_ALIGN_CHK_EN
            m_exc = 1'b0;
`endif
        end else begin
            redirect = jumpD || pcsrcD;
            dest     = jumpD ? pcjumpD : pcbranchD;
            take     = !stallF || flushD;
            if (!m_started) begin
                m_started = 1'b1;
            end else if (m_hold) begin
                if (redirect) begin
                    m_pc = dest; m_hold = bad(dest); m_hold_exc = bad(dest);
                end else if (take) begin
                    give    = 1'b1;
                    g_exc   = m_hold_exc;
                    g_instr = m_hold_exc ? NOP : m_hold_word;
                    g_pc4   = m_hold_exc ? ((m_pc & 32'hFFFF_FFFC) + 32'd4) : (m_pc + 32'd4);
                    m_pc = g_pc4; m_hold = 1'b0; m_hold_exc = 1'b0;
                end
            end else if (imem_ack) begin
                if (redirect || m_kill) begin
                    m_pc = redirect ? dest : m_tgt;
                    m_kill = 1'b0;
                    if (bad(m_pc)) begin m_hold = 1'b1; m_hold_exc = 1'b1; end
                end else if (take) begin
                    give = 1'b1; g_instr = m_pc ^ KEY; g_pc4 = m_pc + 32'd4;
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_hold = 1'b1; m_hold_word = m_pc ^ KEY; m_hold_exc = 1'b0;
                end
            end else if (redirect) begin
                m_kill = 1'b1; m_tgt = dest;
            end
            if (flushD) begin
                m_instr = NOP; m_valid = 1'b0;
`ifdef MINISYS_IF_ALIGN_CHK_EN
                m_exc = 1'b0;
`endif
            end else if (give) begin
                m_instr = g_instr; m_pc4 = g_pc4; m_valid = 1'b1;
`ifdef MINISYS_IF_ALIGN_CHK_EN
                m_exc = g_exc;
`endif
            end
        end
    endtask

    task automatic compare();
        bit exp_req;
        exp_req = m_started && !m_hold;
        chk("m_req",   32'(imem_req), 32'(exp_req));
        chk("m_addr",  imem_addr, m_pc);
        chk("m_instr", instrD, m_instr);
        chk("m_pc4",   pcplus4D, m_pc4);
        chk("m_valid", 32'(validD), 32'(m_valid));
`ifdef MINISYS_IF_ALIGN_CHK_EN
        chk("m_exc",   32'(excD), 32'(m_exc));
`endif
    endtask

    // ---------------- instruction memory ----------------
    int lat_cnt   = 0;
    int fixed_lat = 0;
    bit rand_lat  = 1'b0;
    bit spurious  = 1'b0;

    task automatic mem_drive();
        if (imem_req) begin
            if (lat_cnt <= 0) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr ^ KEY;
                lat_cnt    = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                lat_cnt--;
            end
        end else begin
            imem_ack   = spurious && ($urandom_range(0, 9) == 0);
            imem_rdata = $urandom;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        mem_drive();
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(0, 9))
            0:       t = 32'hFFFF_FFF8;
            1:       t = ($urandom & 32'h0000_0FFF) | 32'h0000_0001;
            default: t = $urandom & 32'h0000_0FFC;
        endcase
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b1; stallF = 1'b0; flushD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0;
        pcbranchD = 32'd0; pcjumpD = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;

        // Reset state
        cycle();
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_addr",  imem_addr, 32'd0);
        chk("rst_valid", 32'(validD), 32'd0);
        chk("rst_instr", instrD, NOP);
        chk("rst_pc4",   pcplus4D, 32'd0);
        clrn = 1'b0;

        // Zero-wait streaming
        cycle();
        chk("t1_req",    32'(imem_req), 32'd1);
        chk("t1_addr0",  imem_addr, 32'h0);
        cycle();
        chk("t1_addr4",  imem_addr, 32'h4);
        chk("t1_instr0", instrD, 32'hA5A5_0000);
        chk("t1_pc4_0",  pcplus4D, 32'h4);
        chk("t1_valid",  32'(validD), 32'd1);
        fixed_lat = 3;
        cycle();
        chk("t1_addr8",  imem_addr, 32'h8);
        chk("t1_instr4", instrD, 32'hA5A5_0004);
        chk("t1_pc4_4",  pcplus4D, 32'h8);

        // Stall at the ack of 0x10 -> hold, then release
        for (int i = 0; i < 20 && !(imem_ack && imem_addr == 32'h10); i++) cycle();
        chk("t2_at10",   imem_addr, 32'h10);
        chk("t2_ack",    32'(imem_ack), 32'd1);
        stallF = 1'b1;
        cycle();
        chk("t2_hreq",   32'(imem_req), 32'd0);
        chk("t2_hinstr", instrD, 32'hA5A5_000C);
        chk("t2_hpc4",   pcplus4D, 32'h10);
        cycle();
        chk("t2_hreq2",  32'(imem_req), 32'd0);
        stallF = 1'b0;
        cycle();
        chk("t2_instr",  instrD, 32'hA5A5_0010);
        chk("t2_pc4",    pcplus4D, 32'h14);
        chk("t2_addr",   imem_addr, 32'h14);
        chk("t2_req",    32'(imem_req), 32'd1);

        // Branch while the fetch of 0x20 is outstanding
        for (int i = 0; i < 40 && !(imem_addr == 32'h20 && !imem_ack); i++) cycle();
        chk("t3_at20",   imem_addr, 32'h20);
        pcsrcD = 1'b1; pcbranchD = 32'h40;
        cycle();
        pcsrcD = 1'b0; pcbranchD = 32'h0;
        chk("t3_keep",   imem_addr, 32'h20);
        for (int i = 0; i < 10 && !imem_ack; i++) begin
            cycle();
            chk("t3_keepw", imem_addr, 32'h20);
        end
        chk("t3_ack",    32'(imem_ack), 32'd1);
        cycle();
        chk("t3_instr",  instrD, 32'hA5A5_001C);
        chk("t3_pc4",    pcplus4D, 32'h20);
        chk("t3_addr",   imem_addr, 32'h40);

        // Jump and branch together, with flush
        jumpD = 1'b1; pcjumpD = 32'h100; pcsrcD = 1'b1; pcbranchD = 32'h200; flushD = 1'b1;
        cycle();
        jumpD = 1'b0; pcsrcD = 1'b0; flushD = 1'b0;
        chk("t4_instr",  instrD, NOP);
        chk("t4_valid",  32'(validD), 32'd0);
        chk("t4_pc4",    pcplus4D, 32'h20);
        for (int i = 0; i < 10 && imem_addr == 32'h40; i++) cycle();
        chk("t4_addr",   imem_addr, 32'h100);
        chk("t4_req",    32'(imem_req), 32'd1);

        // Reset while waiting at 0x30; ack in S_IDLE is ignored
        jumpD = 1'b1; pcjumpD = 32'h30;
        cycle();
        jumpD = 1'b0;
        for (int i = 0; i < 15 && imem_addr != 32'h30; i++) cycle();
        chk("t5_at30",   imem_addr, 32'h30);
        chk("t5_wait",   32'(imem_ack), 32'd0);
        clrn = 1'b1;
        cycle();
        clrn = 1'b0;
        chk("t5_rreq",   32'(imem_req), 32'd0);
        chk("t5_raddr",  imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; lat_cnt = 2;
        cycle();
        chk("t5_addr0",  imem_addr, 32'h0);
        chk("t5_req",    32'(imem_req), 32'd1);
        chk("t5_valid",  32'(validD), 32'd0);
        chk("t5_instr",  instrD, NOP);
        for (int i = 0; i < 10 && !imem_ack; i++) begin
            cycle();
            chk("t5_validw", 32'(validD), 32'd0);
        end
        cycle();
        chk("t5_first",  instrD, 32'hA5A5_0000);
        chk("t5_fvalid", 32'(validD), 32'd1);
        chk("t5_faddr",  imem_addr, 32'h4);

        // Misaligned jump target
        jumpD = 1'b1; pcjumpD = 32'h102;
        cycle();
        jumpD = 1'b0;
        for (int i = 0; i < 20 && !(imem_req && imem_addr != 32'h4); i++) cycle();
`ifdef MINISYS_IF_ALIGN_CHK_EN
        chk("t6_addr",   imem_addr, 32'h104);
        chk("t6_exc",    32'(excD), 32'd1);
        chk("t6_instr",  instrD, NOP);
        chk("t6_valid",  32'(validD), 32'd1);
        chk("t6_pc4",    pcplus4D, 32'h104);
`else
        chk("t6_addr",   imem_addr, 32'h102);
        chk("t6_req",    32'(imem_req), 32'd1);
`endif

        // PC wrap-around at the top of the address space
        fixed_lat = 0;
        jumpD = 1'b1; pcjumpD = 32'hFFFF_FFFC;
        cycle();
        jumpD = 1'b0;
        for (int i = 0; i < 20 && !(imem_ack && imem_addr == 32'hFFFF_FFFC); i++) cycle();
        chk("t7_atop",   imem_addr, 32'hFFFF_FFFC);
        cycle();
        chk("t7_addr",   imem_addr, 32'h0);
        chk("t7_pc4",    pcplus4D, 32'h0);
        chk("t7_instr",  instrD, 32'h5A5A_FFFC);

        // Randomized traffic against the reference model
        rand_lat = 1'b1; spurious = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            stallF    = ($urandom_range(0, 9) < 3);
            flushD    = ($urandom_range(0, 9) == 0);
            jumpD     = ($urandom_range(0, 15) == 0);
            pcsrcD    = ($urandom_range(0, 11) == 0);
            pcjumpD   = rand_target();
            pcbranchD = rand_target();
            clrn      = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
